// File: rtl/hilo_ctrl_if.sv
// Bundles the hilo_ctrl ports toward the control unit and the div/mult units.
// The slave modport is the controller's view; the master modport is the view of its surroundings.
interface hilo_ctrl_if;
    logic        op_start;
    logic [1:0]  op_sel;
    logic [31:0] wdata;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        div_zero_exc;
    logic        timeout_exc;
    logic        div_control;
    logic        div_stop;
    logic        div_zero;
    logic [31:0] div_hi;
    logic [31:0] div_lo;
    logic        mult_control;
    logic        mult_stop;
    logic [31:0] mult_hi;
    logic [31:0] mult_lo;

    modport slave (
        input  op_start, op_sel, wdata,
        input  div_stop, div_zero, div_hi, div_lo,
        input  mult_stop, mult_hi, mult_lo,
        output hi, lo, busy, done, div_zero_exc, timeout_exc,
        output div_control, mult_control
    );

    modport master (
        output op_start, op_sel, wdata,
        output div_stop, div_zero, div_hi, div_lo,
        output mult_stop, mult_hi, mult_lo,
        input  hi, lo, busy, done, div_zero_exc, timeout_exc,
        input  div_control, mult_control
    );
endinterface

// File: rtl/hilo_ctrl.sv
// HI/LO owner and div/mult sequencer for the multicycle MIPS datapath.
// Define HILO_TIMEOUT_EN to build the WAIT timeout counter and timeout_exc.
module hilo_ctrl #(
    parameter int TIMEOUT = 48
) (
    input  logic        clk,
    input  logic        reset,
    hilo_ctrl_if.slave  bus
);
    // state   | meaning
    // S_IDLE  | accepts op_start; mthi/mtlo complete here
    // S_START | one-cycle start pulse to the selected unit; stale stop/zero ignored
    // S_WAIT  | waits for zero/stop (or timeout) from the selected unit
    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT} state_t;

    state_t      r_state, w_next;
    logic        r_sel_div, w_sel_div_nxt;
    logic [31:0] r_hi, r_lo, w_hi_nxt, w_lo_nxt;
    logic        r_busy, r_done, r_dz_exc, r_div_ctl, r_mul_ctl;
    logic        w_done_nxt, w_dz_nxt, w_div_ctl_nxt, w_mul_ctl_nxt;
    logic        w_unit_stop;

`ifdef HILO_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_TC = 8'(TIMEOUT);
    logic [7:0] r_cnt;
    logic       r_to_exc, w_to_nxt, w_timeout;

    // Held at zero outside WAIT so it is already clear on the first WAIT cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_cnt <= 8'd0;
        else if (r_state != S_WAIT)
            r_cnt <= 8'd0;
        else
            r_cnt <= r_cnt + 8'd1;
    end

    assign w_timeout       = (r_cnt == TIMEOUT_TC);
    assign bus.timeout_exc = r_to_exc;
`else
    assign bus.timeout_exc = 1'b0;
`endif

    assign w_unit_stop = r_sel_div ? bus.div_stop : bus.mult_stop;

    always_comb begin
        w_next        = r_state;
        w_sel_div_nxt = r_sel_div;
        w_hi_nxt      = r_hi;
        w_lo_nxt      = r_lo;
        w_done_nxt    = 1'b0;
        w_dz_nxt      = 1'b0;
        w_div_ctl_nxt = 1'b0;
        w_mul_ctl_nxt = 1'b0;
`ifdef HILO_TIMEOUT_EN
        w_to_nxt      = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (bus.op_start) begin
                    case (bus.op_sel)
                        2'b00: begin
                            w_sel_div_nxt = 1'b0;
                            w_mul_ctl_nxt = 1'b1;
                            w_next        = S_START;
                        end
                        2'b01: begin
                            w_sel_div_nxt = 1'b1;
                            w_div_ctl_nxt = 1'b1;
                            w_next        = S_START;
                        end
                        2'b10: begin
                            w_hi_nxt   = bus.wdata;
                            w_done_nxt = 1'b1;
                        end
                        default: begin
                            w_lo_nxt   = bus.wdata;
                            w_done_nxt = 1'b1;
                        end
                    endcase
                end
            end
            S_START: w_next = S_WAIT;
            S_WAIT: begin
                if (r_sel_div && bus.div_zero) begin
                    w_dz_nxt = 1'b1;
                    w_next   = S_IDLE;
                end else if (w_unit_stop) begin
                    w_hi_nxt   = r_sel_div ? bus.div_hi : bus.mult_hi;
                    w_lo_nxt   = r_sel_div ? bus.div_lo : bus.mult_lo;
                    w_done_nxt = 1'b1;
                    w_next     = S_IDLE;
                end
`ifdef HILO_TIMEOUT_EN
                else if (w_timeout) begin
                    w_to_nxt = 1'b1;
                    w_next   = S_IDLE;
                end
`endif
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_sel_div <= 1'b0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_dz_exc  <= 1'b0;
            r_div_ctl <= 1'b0;
            r_mul_ctl <= 1'b0;
`ifdef HILO_TIMEOUT_EN
            r_to_exc  <= 1'b0;
`endif
        end else begin
            r_state   <= w_next;
            r_sel_div <= w_sel_div_nxt;
            r_hi      <= w_hi_nxt;
            r_lo      <= w_lo_nxt;
            r_busy    <= (w_next != S_IDLE);
            r_done    <= w_done_nxt;
            r_dz_exc  <= w_dz_nxt;
            r_div_ctl <= w_div_ctl_nxt;
            r_mul_ctl <= w_mul_ctl_nxt;
`ifdef HILO_TIMEOUT_EN
            r_to_exc  <= w_to_nxt;
`endif
        end
    end

    assign bus.hi           = r_hi;
    assign bus.lo           = r_lo;
    assign bus.busy         = r_busy;
    assign bus.done         = r_done;
    assign bus.div_zero_exc = r_dz_exc;
    assign bus.div_control  = r_div_ctl;
    assign bus.mult_control = r_mul_ctl;
endmodule

// File: tb/tb_hilo_ctrl.sv
// Randomized self-checking bench for hilo_ctrl with behavioural div/mult units
// and a transaction-level HI/LO reference model.
module tb_hilo_ctrl;
    localparam int TB_TIMEOUT = 8;

    logic clk = 1'b0;
    logic reset;
    hilo_ctrl_if bus();

    hilo_ctrl #(.TIMEOUT(TB_TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // reference architectural state
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    // operands and latency knobs for the unit models
    logic [31:0] op_a, op_b;
    int  div_lat = 3;
    int  mul_lat = 3;
    bit  mul_never = 1'b0;
    bit  d_run, m_run;
    int  d_cnt, m_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // divider: clears stop and registers div_zero on the start pulse, stop after div_lat cycles
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.div_stop <= 1'b0; bus.div_zero <= 1'b0;
            bus.div_hi <= 32'd0; bus.div_lo <= 32'd0;
            d_run <= 1'b0; d_cnt <= 0;
        end else if (bus.div_control) begin
            bus.div_stop <= 1'b0;
            bus.div_zero <= (op_b == 32'd0);
            d_run <= 1'b1;
            d_cnt <= div_lat;
        end else if (d_run) begin
            if (d_cnt <= 1) begin
                d_run <= 1'b0;
                bus.div_stop <= 1'b1;
                if (op_b != 32'd0) begin
                    bus.div_hi <= $signed(op_a) % $signed(op_b);
                    bus.div_lo <= $signed(op_a) / $signed(op_b);
                end else begin
                    bus.div_hi <= 32'hDEAD_BEEF;
                    bus.div_lo <= 32'hDEAD_BEEF;
                end
            end else begin
                d_cnt <= d_cnt - 1;
            end
        end
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.mult_stop <= 1'b0;
            bus.mult_hi <= 32'd0; bus.mult_lo <= 32'd0;
            m_run <= 1'b0; m_cnt <= 0;
        end else if (bus.mult_control) begin
            bus.mult_stop <= 1'b0;
            m_run <= !mul_never;
            m_cnt <= mul_lat;
        end else if (m_run) begin
            if (m_cnt <= 1) begin
                logic signed [63:0] p;
                p = $signed(op_a) * $signed(op_b);
                m_run <= 1'b0;
                bus.mult_stop <= 1'b1;
                bus.mult_hi <= p[63:32];
                bus.mult_lo <= p[31:0];
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic idle_chk(input int n, input string tag);
        int pulses = 0;
        bus.op_start = 1'b0;
        repeat (n) begin
            step();
            pulses += int'(bus.done) + int'(bus.div_zero_exc) + int'(bus.timeout_exc)
                    + int'(bus.div_control) + int'(bus.mult_control);
        end
        chk(tag, 32'(pulses), 32'd0);
    endtask

    // Caller is in cycle 0 (1 time unit after an edge); returns in the done/exception cycle.
    task automatic run_op(input logic [1:0] sel, input logic [31:0] a, input logic [31:0] b,
                          input bit spam);
        int  cyc, stop_cyc, extra_ctl;
        bit  fin, busy_ok, exp_dz, unit_stop;
        logic signed [63:0] p;
        bus.op_start = 1'b1; bus.op_sel = sel; bus.wdata = a;
        op_a = a; op_b = b;
        step();
        if (sel[1]) begin
            bus.op_start = 1'b0;
            if (sel == 2'b10) m_hi = a; else m_lo = a;
            chk("mt_done", 32'(bus.done), 32'd1);
            chk("mt_busy", 32'(bus.busy), 32'd0);
            chk("mt_hi", bus.hi, m_hi);
            chk("mt_lo", bus.lo, m_lo);
            return;
        end
        bus.op_start = spam;
        chk("start_busy", 32'(bus.busy), 32'd1);
        chk("start_ctl", 32'(sel[0] ? bus.div_control : bus.mult_control), 32'd1);
        chk("start_other", 32'(sel[0] ? bus.mult_control : bus.div_control), 32'd0);
        cyc = 1; stop_cyc = -1; extra_ctl = 0; fin = 1'b0; busy_ok = 1'b1;
        exp_dz = sel[0] && (b == 32'd0);
        while (!fin && cyc < 400) begin
            step();
            cyc++;
            if (bus.div_control || bus.mult_control) extra_ctl++;
            unit_stop = sel[0] ? bus.div_stop : bus.mult_stop;
            if (bus.done || bus.div_zero_exc || bus.timeout_exc) fin = 1'b1;
            else begin
                if (!bus.busy) busy_ok = 1'b0;
                if (stop_cyc < 0 && unit_stop) stop_cyc = cyc;
            end
        end
        bus.op_start = 1'b0;
        chk("op_finished", 32'(fin), 32'd1);
        chk("extra_ctl", 32'(extra_ctl), 32'd0);
        chk("busy_hold", 32'(busy_ok), 32'd1);
        if (exp_dz) begin
            chk("dz_exc", 32'(bus.div_zero_exc), 32'd1);
            chk("dz_cycle", 32'(cyc), 32'd3);
            chk("dz_nodone", 32'(bus.done), 32'd0);
        end else begin
            if (sel[0]) begin
                m_hi = $signed(a) % $signed(b);
                m_lo = $signed(a) / $signed(b);
            end else begin
                p = $signed(a) * $signed(b);
                m_hi = p[63:32];
                m_lo = p[31:0];
            end
            chk("done", 32'(bus.done), 32'd1);
            chk("done_lat", 32'(cyc), 32'(stop_cyc + 1));
            chk("done_busy", 32'(bus.busy), 32'd0);
        end
        chk("hi", bus.hi, m_hi);
        chk("lo", bus.lo, m_lo);
    endtask

    initial begin
        logic [1:0]  sel;
        logic [31:0] a, b;
        int          to_n, to_cyc, busy_drop, pulses;

        reset = 1'b1;
        bus.op_start = 1'b0; bus.op_sel = 2'b00; bus.wdata = 32'd0;
        op_a = 32'd0; op_b = 32'd1;
        repeat (3) step();
        reset = 1'b0;
        step();
        chk("rst_hi", bus.hi, 32'd0);
        chk("rst_lo", bus.lo, 32'd0);
        chk("rst_flags", 32'({bus.busy, bus.done, bus.div_zero_exc, bus.timeout_exc,
                              bus.div_control, bus.mult_control}), 32'd0);

        // 7 / -2 : remainder 1, quotient -3
        div_lat = 6;
        run_op(2'b01, 32'd7, -32'sd2, 1'b0);
        chk("t1_hi", bus.hi, 32'h0000_0001);
        chk("t1_lo", bus.lo, 32'hFFFF_FFFD);
        idle_chk(3, "t1_single_done");

        // -7 / 2 then mult issued in the done cycle
        div_lat = 2; mul_lat = 4;
        run_op(2'b01, -32'sd7, 32'd2, 1'b0);
        chk("t2_div_hi", bus.hi, 32'hFFFF_FFFF);
        chk("t2_div_lo", bus.lo, 32'hFFFF_FFFD);
        run_op(2'b00, 32'h0001_0000, 32'h0001_0000, 1'b0);
        chk("t2_mul_hi", bus.hi, 32'h0000_0001);
        chk("t2_mul_lo", bus.lo, 32'h0000_0000);
        idle_chk(2, "t2_quiet");

        // mthi/mtlo then divide by zero
        run_op(2'b10, 32'h11, 32'd0, 1'b0);
        run_op(2'b11, 32'h22, 32'd0, 1'b0);
        div_lat = 1;
        run_op(2'b01, 32'd5, 32'd0, 1'b0);
        chk("t3_hi", bus.hi, 32'h11);
        chk("t3_lo", bus.lo, 32'h22);
        idle_chk(6, "t3_no_done");

        // op_start held high through a whole div
        div_lat = 7;
        run_op(2'b01, 32'd100, -32'sd9, 1'b1);
        idle_chk(5, "t4_no_requeue");

        // random mix, gaps of 0..2 cycles
        for (int i = 0; i < 60; i++) begin
            sel = 2'($urandom_range(0, 3));
            a = $urandom;
            b = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(1, 40));
            if ($urandom_range(0, 1) == 0) b = -b;
            if ($urandom_range(0, 9) == 0) b = 32'd0;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd3;
            div_lat = $urandom_range(1, 10);
            mul_lat = $urandom_range(1, 10);
            run_op(sel, a, b, $urandom_range(0, 3) == 0);
            repeat ($urandom_range(0, 2)) step();
        end

        // reset during WAIT cycle 10 of a long div
        div_lat = 30;
        idle_chk(1, "t5_pre");
        bus.op_start = 1'b1; bus.op_sel = 2'b01; op_a = 32'd1000; op_b = 32'd7;
        step();
        bus.op_start = 1'b0;
        repeat (10) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
        chk("t5_hi", bus.hi, 32'd0);
        chk("t5_lo", bus.lo, 32'd0);
        chk("t5_flags", 32'({bus.busy, bus.done, bus.div_zero_exc, bus.timeout_exc,
                             bus.div_control, bus.mult_control}), 32'd0);
        idle_chk(40, "t5_no_late_pulse");

        // mult that never finishes
        run_op(2'b10, 32'hAAAA_0001, 32'd0, 1'b0);
        run_op(2'b11, 32'h5555_0002, 32'd0, 1'b0);
        mul_never = 1'b1;
        bus.op_start = 1'b1; bus.op_sel = 2'b00; op_a = 32'd3; op_b = 32'd4;
        step();
        bus.op_start = 1'b0;
`ifdef HILO_TIMEOUT_EN
        to_n = 0; to_cyc = -1; pulses = 0;
        for (int c = 2; c < 40; c++) begin
            step();
            if (bus.timeout_exc) begin
                to_n++;
                if (to_cyc < 0) to_cyc = c;
            end
            pulses += int'(bus.done) + int'(bus.div_zero_exc);
        end
        chk("t6_to_count", 32'(to_n), 32'd1);
        chk("t6_to_cycle", 32'(to_cyc), 32'(TB_TIMEOUT + 3));
        chk("t6_busy", 32'(bus.busy), 32'd0);
        chk("t6_other", 32'(pulses), 32'd0);
        chk("t6_hi", bus.hi, m_hi);
        chk("t6_lo", bus.lo, m_lo);
`else
        busy_drop = 0; pulses = 0; to_n = 0; to_cyc = 0;
        repeat (100) begin
            step();
            if (!bus.busy) busy_drop++;
            pulses += int'(bus.done) + int'(bus.div_zero_exc) + int'(bus.timeout_exc);
        end
        chk("t6_busy_stuck", 32'(busy_drop), 32'd0);
        chk("t6_no_pulse", 32'(pulses), 32'd0);
        chk("t6_hi", bus.hi, m_hi);
        chk("t6_lo", bus.lo, m_lo);
        reset = 1'b1;
        step();
        reset = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
        chk("t6_rst_busy", 32'(bus.busy), 32'd0);
        chk("t6_rst_hi", bus.hi, m_hi);
`endif
        mul_never = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/hilo_ctrl.md
# hilo_ctrl

Sequencer and HI/LO register owner for the multicycle MIPS datapath. Sits between the control unit and the multicycle `div` and `mult` units. Issues their one-cycle start pulses and waits for completion. Captures results into the architectural HI/LO registers, executes `mthi`/`mtlo`, and raises divide-by-zero and timeout exceptions to the control unit.

## Interface
- `TIMEOUT`, default 48: maximum number of WAIT cycles before abort. Used only with `HILO_TIMEOUT_EN`. Legal range 1..255.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `op_start`  in  1  request strobe, sampled only in IDLE.
- `op_sel`  in  2  operation select: 00 mult, 01 div, 10 mthi, 11 mtlo.
- `wdata`  in  32  source value for mthi/mtlo.
- `div_control`  out  1  start pulse to divider.
- `div_stop`  in  1  divider finished (level, held until next start).
- `div_zero`  in  1  divider saw zero divisor (level).
- `div_hi`, `div_lo`  in  32 each  divider remainder and quotient.
- `mult_control`  out  1  start pulse to multiplier.
- `mult_stop`  in  1  multiplier finished (level, held until next start).
- `mult_hi`, `mult_lo`  in  32 each  product upper and lower words.
- `hi`, `lo`  out  32 each  architectural HI/LO (mfhi/mflo read these directly).
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  one-cycle pulse: operation completed and HI/LO updated.
- `div_zero_exc`  out  1  one-cycle pulse: div aborted, HI/LO unchanged.
- `timeout_exc`  out  1  one-cycle pulse: unit never finished, HI/LO unchanged.

## Operation
- States: IDLE, START, WAIT. All outputs are registered.
- IDLE, `op_start`=1, `op_sel`=10/11:
  - Writes `wdata` into HI or LO at that edge.
  - `done`=1 the next cycle.
  - Stays in IDLE.
- IDLE, `op_start`=1, `op_sel`=00/01:
  - Latches the unit selection and goes to START.
  - The selected `*_control` is 1 for exactly the one START cycle.
- START: ignores all `*_stop`/`div_zero` inputs, because stale levels from the previous op are still present. Goes to WAIT unconditionally.
- WAIT, priority order:
  1. div selected and `div_zero`=1: `div_zero_exc` pulse, go to IDLE.
  2. Selected `*_stop`=1: copy the unit's hi/lo into HI/LO, `done` pulse, go to IDLE.
  3. Timeout (if compiled in): `timeout_exc` pulse, go to IDLE.
  4. Otherwise stay.
- Only the selected unit's inputs are examined. The other unit's signals are don't-care.
- `op_start` while `busy`: ignored, not queued.
- HI/LO change only on `done`. Exceptions and timeouts never modify them.
- Results are copied unmodified. Sign fix-up is the responsibility of the div/mult units: remainder takes the dividend's sign, quotient is negative iff the operand signs differ.

## Timing
- Reset values: `hi`=0, `lo`=0, `busy`=0, `done`=0, `div_zero_exc`=0, `timeout_exc`=0, `div_control`=0, `mult_control`=0. State IDLE, timeout counter 0.
- Reset asserted mid-operation: immediate return to IDLE, HI/LO cleared, no pulse emitted. The external unit is reset by the same `reset`.
- Cycle 0: `op_start` sampled. Cycle 1: START, `*_control`=1. Cycle 2 onward: WAIT.
- div_zero: the divider registers `div_zero` at the cycle-1→2 edge. `div_zero_exc`=1 in cycle 3.
- Normal completion: if `*_stop` is first high in cycle N, HI/LO are updated and `done`=1 in cycle N+1. `busy` is already 0 in that cycle.
- A new `op_start` is accepted in the `done`/exception cycle. Back-to-back ops are therefore possible with no dead cycle.
- mthi/mtlo: `op_start` in cycle 0 makes HI/LO valid and `done`=1 in cycle 1. `busy` stays 0.
- Timeout counter:
  - Clears on entry to WAIT and increments each WAIT cycle.
  - `timeout_exc` fires in the cycle after the counter reaches `TIMEOUT` with no stop/zero seen.
  - Stop and timeout in the same cycle: stop wins.

## Configuration
- `HILO_TIMEOUT_EN` defined: the 8-bit WAIT counter and the `timeout_exc` logic are built.
- `HILO_TIMEOUT_EN` undefined:
  - No counter is built, and WAIT persists until stop/zero or reset.
  - `timeout_exc` is tied to 0 and the `TIMEOUT` parameter is ignored.

## Test plan
- div A=7, B=-2 with the real divider: `done` pulses once, `hi`=1, `lo`=-3 (0xFFFFFFFD). `busy` is high from cycle 1 until the done cycle.
- div A=-7, B=2, then mult 0x00010000×0x00010000 back-to-back in the done cycle:
  - div result: `hi`=-1, `lo`=-3.
  - mult result: `hi`=1, `lo`=0.
- div A=5, B=0 after HI=0x11, LO=0x22 set via mthi/mtlo: `div_zero_exc`=1 in cycle 3. No `done` pulse. HI/LO stay 0x11/0x22.
- `op_start` asserted every cycle during a div: exactly one `div_control` pulse, exactly one `done`.
- Reset asserted in WAIT cycle 10 of a div: all outputs are 0 next cycle. No pulses follow when the divider would have finished.
- With `HILO_TIMEOUT_EN`, `TIMEOUT`=8, and a stub mult that never raises stop: `timeout_exc` pulses once, HI/LO unchanged, `busy` returns to 0. Without the macro, `busy` stays high indefinitely.
